// File: rtl/mdu_pkg.sv
// Shared constants and types for the multi-cycle multiply/divide unit.
// FS codes match the ALU decode so both paths agree on the encoding.
package mdu_pkg;

    localparam logic [4:0] FS_MULT   = 5'h1E;
    localparam logic [4:0] FS_DIV    = 5'h1F;
    localparam int         MDU_STEPS = 32;
    localparam int         CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } mdu_op_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration on the {hi, lo} accumulator: shift-add for multiply,
// restoring shift-subtract for divide (quotient bits enter at the lsb).
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdu_op_e              op,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     operand_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    always_comb begin
        hi     = acc_i[2*WIDTH-1:WIDTH];
        lo     = acc_i[WIDTH-1:0];
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, operand_i} : '0);
        rem_sh = {hi, lo[WIDTH-1]};
        diff   = rem_sh - {1'b0, operand_i};
        acc_o  = acc_i;
        if (op == OP_MULT) begin
            // Carry of the add becomes the new top bit as the pair shifts right.
            acc_o = {sum, lo[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_o = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {rem_sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Iterative signed multiply/divide sequencer owning HI/LO. Operates on
// magnitudes for 32 steps, then applies sign correction in a final FIX cycle.
module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int         WIDTH   = 32,
    parameter logic [4:0] FS_MULT = mdu_pkg::FS_MULT,
    parameter logic [4:0] FS_DIV  = mdu_pkg::FS_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       FS,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
    input  logic             rd_req,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output mdu_state_e       state_dbg
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MDU_STEPS - 1);

    mdu_state_e           state_q, state_d;
    mdu_op_e              op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 s_neg_q, s_neg_d;
    logic                 t_neg_q, t_neg_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic [2*WIDTH-1:0]   step_acc;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     mag_s;
    logic [WIDTH-1:0]     mag_t;
    logic                 accept;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .op        (op_q),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc)
    );

    always_comb begin
        mag_s    = S[WIDTH-1] ? -S : S;
        mag_t    = T[WIDTH-1] ? -T : T;
        accept   = start && ((FS == FS_MULT) || (FS == FS_DIV));
        prod_fix = (s_neg_q ^ t_neg_q) ? -acc_q : acc_q;
        quot_fix = (s_neg_q ^ t_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        // Remainder follows the dividend's sign, giving truncating division.
        rem_fix  = s_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        s_neg_d = s_neg_q;
        t_neg_d = t_neg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_hi) hi_d = wd;
                if (wr_lo) lo_d = wd;
                if (accept) begin
                    s_neg_d = S[WIDTH-1];
                    t_neg_d = T[WIDTH-1];
                    cnt_d   = '0;
                    if (FS == FS_DIV) begin
                        op_d    = OP_DIV;
                        acc_d   = {{WIDTH{1'b0}}, mag_s};
                        opnd_d  = mag_t;
                        dz_d    = (T == '0);
                        state_d = (T == '0) ? FIX : CALC;
                    end else begin
                        op_d    = OP_MULT;
                        acc_d   = {{WIDTH{1'b0}}, mag_t};
                        opnd_d  = mag_s;
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = FIX;
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (op_q == OP_MULT) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dz_q) begin
                    // Dividend magnitude is still untouched in the low half.
                    hi_d = s_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            s_neg_q <= 1'b0;
            t_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            s_neg_q <= s_neg_d;
            t_neg_q <= t_neg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign HI        = hi_q;
    assign LO        = lo_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign stall     = busy & rd_req;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed and random checks of mdu_seq_ctrl with an expected-result queue
// filled at start and drained when done pulses.
module tb_mdu_seq_ctrl;
    import mdu_pkg::*;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [4:0]       fs;
    logic [W-1:0]     s;
    logic [W-1:0]     t;
    logic             wr_hi;
    logic             wr_lo;
    logic [W-1:0]     wd;
    logic             rd_req;
    logic [W-1:0]     hi;
    logic [W-1:0]     lo;
    logic             busy;
    logic             done;
    logic             stall;
    mdu_state_e       state_dbg;

    logic [2*W-1:0]   exp_q[$];
    int               vectors     = 0;
    int               miscompares = 0;

    always #5 clk = ~clk;

    mdu_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .FS        (fs),
        .S         (s),
        .T         (t),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wd        (wd),
        .rd_req    (rd_req),
        .HI        (hi),
        .LO        (lo),
        .busy      (busy),
        .done      (done),
        .stall     (stall),
        .state_dbg (state_dbg)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start one operation, watch the busy window, then compare the popped result.
    task automatic run_op(input logic [4:0] op_fs, input logic [W-1:0] op_s,
                          input logic [W-1:0] op_t, input int lat,
                          input logic rd, input logic inject);
        logic [63:0] want;
        int          n;
        @(negedge clk);
        start = 1'b1; fs = op_fs; s = op_s; t = op_t; rd_req = rd;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            chk("busy_window", busy, 1);
            chk("stall_window", stall, rd);
            if (inject && n == 4) begin
                start = 1'b1; fs = FS_DIV; s = 100; t = 7;
                wr_hi = 1'b1; wd = 32'hDEAD;
            end else begin
                start = 1'b0; wr_hi = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0; wr_hi = 1'b0;
        chk("latency", n, lat);
        chk("busy_at_done", busy, 0);
        chk("stall_at_done", stall, 0);
        rd_req = 1'b0;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        chk("hi_result", hi, want[63:32]);
        chk("lo_result", lo, want[31:0]);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        logic signed [63:0] p;
        logic signed [W-1:0] q;
        logic signed [W-1:0] r;
        logic [W-1:0]        rs;
        logic [W-1:0]        rt;

        reset = 1'b1; start = 1'b0; fs = '0; s = '0; t = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wd = '0; rd_req = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state_dbg, IDLE);
        reset = 1'b0;

        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
        run_op(FS_MULT, 32'd7, 32'hFFFFFFFD, 33, 1'b1, 1'b0);

        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op(FS_DIV, 32'hFFFFFFF9, 32'd2, 33, 1'b0, 1'b0);

        exp_q.push_back({32'h00000000, 32'h80000000});
        run_op(FS_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 1'b0, 1'b0);

        exp_q.push_back({32'h12345678, 32'hFFFFFFFF});
        run_op(FS_DIV, 32'h12345678, 32'h0, 1, 1'b0, 1'b0);

        // Unknown FS in IDLE must not start anything.
        @(negedge clk);
        start = 1'b1; fs = 5'h10; s = 5; t = 5;
        @(negedge clk);
        start = 1'b0;
        chk("bad_fs_ignored", busy, 0);

        exp_q.push_back({32'h0, 32'd12});
        run_op(FS_MULT, 32'd3, 32'd4, 33, 1'b0, 1'b1);

        @(negedge clk);
        wr_lo = 1'b1; wd = 32'hBEEF;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("mtlo_lo", lo, 32'hBEEF);
        chk("mtlo_hi_kept", hi, 0);

        rd_req = 1'b1;
        #1;
        chk("stall_idle", stall, 0);
        rd_req = 1'b0;

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; fs = FS_MULT; s = 32'h10000; t = 32'h10000;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        exp_q.push_back({32'h0, 32'd4});
        run_op(FS_MULT, 32'd2, 32'd2, 33, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rs = $urandom;
            rt = $urandom_range(0, 1) ? $urandom : W'($urandom_range(1, 1000));
            if (rt == 0) rt = 1;
            if (i % 2 == 0) begin
                p = $signed(rs) * $signed(rt);
                exp_q.push_back(p);
                run_op(FS_MULT, rs, rt, 33, 1'(i % 3 == 0), 1'b0);
            end else begin
                if (rs == 32'h80000000) rs = 32'h7FFFFFFF;
                q = $signed(rs) / $signed(rt);
                r = $signed(rs) % $signed(rt);
                exp_q.push_back({r, q});
                run_op(FS_DIV, rs, rt, 33, 1'b0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
Multi-cycle signed multiply/divide sequencer that owns the HI/LO architectural registers.
It is the iterative, clocked replacement for the single-cycle multiply and divide paths in the ALU wrapper. It uses the same FS codes: 5'h1E = MULT, 5'h1F = DIV.
It sits beside the ALU in EX. The control unit starts an operation, reads HI/LO for MFHI/MFLO, and stalls on busy.

Parameters:
WIDTH, 32, operand/result width; HI and LO are each WIDTH bits.
FS_MULT, 5'h1E, function-select code for signed multiply.
FS_DIV, 5'h1F, function-select code for signed divide.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  operation request, sampled on a clk edge.
FS  in  5  function select; only FS_MULT and FS_DIV are acted on.
S  in  WIDTH  operand S (multiplicand / dividend).
T  in  WIDTH  operand T (multiplier / divisor).
wr_hi  in  1  MTHI write strobe.
wr_lo  in  1  MTLO write strobe.
wd  in  WIDTH  MTHI/MTLO write data.
rd_req  in  1  MFHI/MFLO issue in the current cycle.
HI  out  WIDTH  HI register (product[63:32] or remainder).
LO  out  WIDTH  LO register (product[31:0] or quotient).
busy  out  1  operation in progress.
done  out  1  one-cycle pulse; HI/LO were just updated by an operation.
stall  out  1  combinational: busy & rd_req.

Behaviour:
- Reset: state=IDLE; HI=0, LO=0, busy=0, done=0; all internal accumulators and counters = 0. Reset mid-operation aborts it with no HI/LO update.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with FS in {FS_MULT, FS_DIV} at edge E0 -> latch |S|, |T|, sign(S), sign(T), op; counter=0; busy=1; go to CALC.
  - start with any other FS is ignored.
- CALC:
  - One radix-2 step per edge: MULT = shift-add; DIV = restoring shift-subtract.
  - Counter increments each edge; after 32 steps (edges E1..E32) go to FIX.
- FIX, edge E33:
  - Apply sign correction and write HI/LO; done=1 for exactly one cycle; busy=0; return to IDLE.
  - Result latency is 33 edges after start is sampled.
- Sign rules:
  - MULT: 64-bit product is negated iff sign(S)^sign(T).
  - DIV: quotient is negated iff sign(S)^sign(T); remainder takes the sign of S. This gives truncating division.
  - MIN/-1: quotient=32'h80000000, HI=0. No trap.
- Divide by zero (T==0 at accept): skip CALC; E0 goes to FIX; at E1 write HI=S, LO=32'hFFFFFFFF, done=1.
- start while busy: ignored; the in-flight operation is not disturbed.
- wr_hi/wr_lo:
  - Honoured in IDLE only, on the clk edge; dropped while busy.
  - If a start is also accepted at the same edge, the write still lands first. The operation result later overwrites it.
- rd_req while busy -> stall=1. HI/LO outputs hold their old values until the done edge.
- done and busy are never high simultaneously.

Decomposition:
- Package mdu_pkg:
  - FS_MULT and FS_DIV constants, shared with the ALU decode.
  - State enum {IDLE, CALC, FIX}.
  - MDU_STEPS=32 and the counter width (6).
- One combinational sub-module, mdu_iter_step:
  - Inputs: op, accumulator, operand.
  - Output: next accumulator/quotient bit for one shift-add or restoring-subtract step.
- The controller FSM, sign fix-up and HI/LO registers live in mdu_seq_ctrl.

Test Plan:
- MULT: S=7, T=-3 (32'hFFFFFFFD), start at E0 -> busy over E1..E32; done after E33; HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
- DIV: S=-7, T=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). Second case S=32'h80000000, T=-1 -> LO=32'h80000000, HI=0.
- Divide by zero: S=32'h12345678, T=0 -> done after E1; HI=32'h12345678, LO=32'hFFFFFFFF; busy high exactly one cycle.
- Start while busy and MTHI while busy:
  - Stimulus: start MULT 3*4; at E5 re-assert start DIV 100/7 and pulse wr_hi with 32'hDEAD.
  - Required: both ignored; final HI=0, LO=12.
  - Then, in IDLE, wr_lo with 32'hBEEF -> LO=32'hBEEF on the next edge.
- Stall: rd_req=1 during CALC -> stall=1 every busy cycle; stall=0 in the done cycle. rd_req in IDLE -> stall=0.
- Reset mid-op:
  - Start MULT 0x10000*0x10000; assert reset asynchronously at E10 -> HI=LO=0, busy=0, done=0 immediately.
  - After release, a new MULT 2*2 -> LO=4 after 33 edges.
